iddr_capture_ctrl: RTL and testbench
====================================

IDDR_CAPTURE_CTRL -- requirements
Module: iddr_capture_ctrl

Interface
REQ-001 Parameter WORD_W, default 8, meaning: output word width in bits; shall be even and at least 4.
REQ-002 Parameter SYNC_PAT, default 8'hA5 (WORD_W bits), meaning: alignment pattern hunted before lock.
REQ-003 Port C  input  1  meaning: the single clock; all logic on its rising edge.
REQ-004 Port R_N  input  1  meaning: reset, synchronous and active-low.
REQ-005 Port EN  input  1  meaning: capture enable; 1 = run, 0 = return to IDLE.
REQ-006 Port Q0  input  1  meaning: DDR register output from the C0 (first-half) capture; older bit.
REQ-007 Port Q1  input  1  meaning: DDR register output from the C1 (second-half) capture; newer bit.
REQ-008 Port DDR_CE  output  1  meaning: clock enable to the DDR register pair.
REQ-009 Port DDR_CLR  output  1  meaning: clear to the DDR register pair.
REQ-010 Port DOUT  output  WORD_W  meaning: assembled word; first-received bit in MSB.
REQ-011 Port DVALID  output  1  meaning: DOUT holds an unconsumed word.
REQ-012 Port DREADY  input  1  meaning: consumer accepts DOUT when DVALID=1 and DREADY=1.
REQ-013 Port LOCKED  output  1  meaning: 1 while state is LOCKED.
REQ-014 Port OVF  output  1  meaning: sticky overflow; a word was dropped.

Function
REQ-015 The block shall shift two bits per C cycle into a WORD_W-bit window: window <= {window[WORD_W-3:0], Q0, Q1}.
REQ-016 The block shall implement states IDLE, FLUSH, HUNT, LOCKED.
REQ-017 IDLE: DDR_CE=0, DDR_CLR=0; EN=1 -> FLUSH and OVF cleared.
REQ-018 FLUSH: DDR_CLR=1, DDR_CE=0 for exactly 2 cycles, then -> HUNT.
REQ-019 HUNT: DDR_CE=1; when the updated window equals SYNC_PAT, the block shall go to LOCKED with the word-phase counter at 0; the sync word shall not be output.
REQ-020 LOCKED: DDR_CE=1; the phase counter shall count 0..WORD_W/2-1 and wrap; on each wrap the updated window is a completed word.
REQ-021 A completed word shall load DOUT and set DVALID on the same edge, giving one-cycle latency from the last Q0/Q1 pair to DVALID.
REQ-022 DVALID shall clear on the edge where DREADY=1, unless a new word completes on that edge, in which case DOUT reloads and DVALID stays 1.
REQ-023 If a word completes while DVALID=1 and DREADY=0, the word shall be dropped, DOUT shall hold, and OVF shall be set until reset or IDLE->FLUSH.
REQ-024 EN=0 in any state shall force IDLE on the next edge and clear DVALID, LOCKED, DDR_CE, DDR_CLR; a partial word shall be discarded.
REQ-025 EN=0 and EN=1 sampled in IDLE shall always restart via FLUSH; no state shall be skipped.

Reset
REQ-026 With R_N=0 at a rising edge of C, the block shall enter IDLE and set DOUT=0, DVALID=0, LOCKED=0, OVF=0, DDR_CE=0, DDR_CLR=0, window=0, and phase=0.
REQ-027 Reset shall override EN, DREADY, and all in-flight operations, including reset asserted mid-word or mid-FLUSH.

Configuration
REQ-028 Macro IDDR_CAPTURE_BITSLIP_EN defined: HUNT shall also compare the odd-aligned window {window[WORD_W-2:0], Q0} with SYNC_PAT.
REQ-029 On an odd-aligned match, the block shall enter LOCKED with a slip flag set, and words shall be assembled one bit offset, so each word's last bit is the Q0 of the wrap cycle and Q1 starts the next word.
REQ-030 If the even and odd alignments match on the same cycle, even alignment shall win.
REQ-031 Macro IDDR_CAPTURE_BITSLIP_EN undefined: only the even-aligned compare shall exist, and the slip flag and its logic shall be absent.

Structure
REQ-032 State enumeration constants and the FLUSH length constant (2) shall reside in the shared package iddr_capture_pkg.
REQ-033 The window shift and alignment compare shall be the sub-module iddr_capture_align; the FSM, output buffer, and OVF logic shall stay in the top module.

Verification
REQ-034 Reset sequence: R_N=0 for 3 cycles, then 1 with EN=0 -> all outputs 0 and state IDLE.
REQ-035 Lock and capture: EN=1; after FLUSH, pairs 10,10,01,01 (A5) then 11,00,11,00 (CC), DREADY=1 -> LOCKED=1 on the A5 edge; DOUT=8'hCC with DVALID one pulse 4 cycles later.
REQ-036 Backpressure: locked, DREADY=0, two words 8'h12 then 8'h34 -> DOUT stays 8'h12 and OVF=1; then DREADY=1 -> DVALID clears and OVF stays 1.
REQ-037 Simultaneous accept and complete: DVALID=1 with DREADY=1 on a completion edge -> DOUT takes the new word, DVALID=1, OVF=0.
REQ-038 Abort: EN=0 mid-word (phase 2) -> next edge IDLE with DVALID=0 and LOCKED=0; EN=1 -> DDR_CLR=1 for 2 cycles and OVF cleared.
REQ-039 With IDDR_CAPTURE_BITSLIP_EN: stream 0 followed by A5 shifted by one bit -> LOCKED via odd alignment, and the following word 8'h3C is output intact.

Source files
------------

// File: rtl/iddr_capture_pkg.sv
// Shared types and constants for the IDDR capture controller.
// Optional macro IDDR_CAPTURE_BITSLIP_EN enables odd-alignment (bit-slip) locking.
package iddr_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HUNT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam int unsigned FLUSH_LEN   = 2;
    localparam int unsigned FLUSH_CNT_W = $clog2(FLUSH_LEN);

endpackage

// File: rtl/iddr_capture_align.sv
// Two-bit-per-cycle shift window and sync-pattern compare for the IDDR capture path.
// Macro IDDR_CAPTURE_BITSLIP_EN adds the odd-aligned window and compare.
module iddr_capture_align #(
    parameter int unsigned       WORD_W   = 8,
    parameter logic [WORD_W-1:0] SYNC_PAT = WORD_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              q0,
    input  logic              q1,
    output logic [WORD_W-1:0] window_next,
    output logic              even_match
`ifdef IDDR_CAPTURE_BITSLIP_EN
    ,
    output logic [WORD_W-1:0] window_odd,
    output logic              odd_match
`endif
);

    // Only the low bits of the window ever feed the next word, so only those are stored.
`ifdef IDDR_CAPTURE_BITSLIP_EN
    localparam int unsigned KEEP_W = WORD_W - 1;
`else
    localparam int unsigned KEEP_W = WORD_W - 2;
`endif

    logic [KEEP_W-1:0] window_r;

    // Next window and alignment compare.
    always_comb begin
        window_next = {window_r[WORD_W-3:0], q0, q1};
        even_match  = (window_next == SYNC_PAT);
`ifdef IDDR_CAPTURE_BITSLIP_EN
        window_odd  = {window_r[WORD_W-2:0], q0};
        odd_match   = (window_odd == SYNC_PAT);
`endif
    end

    // Window register; cleared whenever capture is not running so no stale bits match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window_r <= '0;
        end else if (shift_en) begin
            window_r <= window_next[KEEP_W-1:0];
        end else begin
            window_r <= '0;
        end
    end

endmodule

// File: rtl/iddr_capture_ctrl.sv
// IDDR capture controller: flush, hunt for sync, then assemble words with backpressure.
// Macro IDDR_CAPTURE_BITSLIP_EN enables locking on an odd (one-bit-slipped) alignment.
module iddr_capture_ctrl
    import iddr_capture_pkg::*;
#(
    parameter int unsigned       WORD_W   = 8,
    parameter logic [WORD_W-1:0] SYNC_PAT = WORD_W'(8'hA5)
) (
    input  logic              C,
    input  logic              R_N,
    input  logic              EN,
    input  logic              Q0,
    input  logic              Q1,
    output logic              DDR_CE,
    output logic              DDR_CLR,
    output logic [WORD_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              LOCKED,
    output logic              OVF
);

    localparam int unsigned             PHASE_W    = $clog2(WORD_W / 2);
    localparam logic [PHASE_W-1:0]      PHASE_LAST = PHASE_W'(WORD_W / 2 - 1);
    localparam logic [FLUSH_CNT_W-1:0]  FLUSH_LAST = FLUSH_CNT_W'(FLUSH_LEN - 1);

    state_t                   state_r;
    state_t                   state_next_s;
    logic [FLUSH_CNT_W-1:0]   flush_cnt_r;
    logic [PHASE_W-1:0]       phase_r;
    logic [WORD_W-1:0]        dout_r;
    logic                     dvalid_r;
    logic                     ovf_r;
    logic                     ddr_ce_r;
    logic                     ddr_clr_r;
    logic                     locked_r;
    logic                     shift_en_s;
    logic                     lock_s;
    logic                     word_done_s;
    logic [WORD_W-1:0]        word_s;
    logic [WORD_W-1:0]        window_next_s;
    logic                     even_match_s;
`ifdef IDDR_CAPTURE_BITSLIP_EN
    logic [WORD_W-1:0]        window_odd_s;
    logic                     odd_match_s;
    logic                     slip_r;
`endif

    assign shift_en_s = EN && ((state_r == ST_HUNT) || (state_r == ST_LOCKED));

    iddr_capture_align #(
        .WORD_W   (WORD_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_align (
        .clk         (C),
        .rst_n       (R_N),
        .shift_en    (shift_en_s),
        .q0          (Q0),
        .q1          (Q1),
        .window_next (window_next_s),
        .even_match  (even_match_s)
`ifdef IDDR_CAPTURE_BITSLIP_EN
        ,
        .window_odd  (window_odd_s),
        .odd_match   (odd_match_s)
`endif
    );

    // Next-state, lock detect and word-completion decode.
    always_comb begin
        state_next_s = state_r;
        word_s       = window_next_s;
        word_done_s  = 1'b0;
`ifdef IDDR_CAPTURE_BITSLIP_EN
        lock_s = even_match_s | odd_match_s;
        if (slip_r) begin
            word_s = window_odd_s;
        end else begin
            word_s = window_next_s;
        end
`else
        lock_s = even_match_s;
`endif
        if (EN && (state_r == ST_LOCKED) && (phase_r == PHASE_LAST)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (EN) state_next_s = ST_FLUSH;
                else    state_next_s = ST_IDLE;
            end
            ST_FLUSH: begin
                if (!EN)                            state_next_s = ST_IDLE;
                else if (flush_cnt_r == FLUSH_LAST) state_next_s = ST_HUNT;
                else                                state_next_s = ST_FLUSH;
            end
            ST_HUNT: begin
                if (!EN)        state_next_s = ST_IDLE;
                else if (lock_s) state_next_s = ST_LOCKED;
                else             state_next_s = ST_HUNT;
            end
            ST_LOCKED: begin
                if (!EN) state_next_s = ST_IDLE;
                else     state_next_s = ST_LOCKED;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, counters and registered control outputs decoded from the next state.
    always_ff @(posedge C) begin
        if (!R_N) begin
            state_r     <= ST_IDLE;
            flush_cnt_r <= '0;
            phase_r     <= '0;
            ddr_ce_r    <= 1'b0;
            ddr_clr_r   <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            ddr_ce_r  <= (state_next_s == ST_HUNT) || (state_next_s == ST_LOCKED);
            ddr_clr_r <= (state_next_s == ST_FLUSH);
            locked_r  <= (state_next_s == ST_LOCKED);
            if (EN && (state_r == ST_FLUSH)) begin
                flush_cnt_r <= flush_cnt_r + 1'b1;
            end else begin
                flush_cnt_r <= '0;
            end
            // Phase is zero on entry to LOCKED because HUNT holds it at zero.
            if (EN && (state_r == ST_LOCKED)) begin
                phase_r <= (phase_r == PHASE_LAST) ? '0 : phase_r + 1'b1;
            end else begin
                phase_r <= '0;
            end
        end
    end

`ifdef IDDR_CAPTURE_BITSLIP_EN
    // Slip flag: set only when the odd alignment alone produced the lock.
    always_ff @(posedge C) begin
        if (!R_N) begin
            slip_r <= 1'b0;
        end else if (EN && (state_r == ST_HUNT)) begin
            slip_r <= odd_match_s & ~even_match_s;
        end else if (!EN || (state_r != ST_LOCKED)) begin
            slip_r <= 1'b0;
        end
    end
`endif

    // Output word buffer with single-entry handshake and sticky overflow.
    always_ff @(posedge C) begin
        if (!R_N) begin
            dout_r   <= '0;
            dvalid_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (!EN) begin
            dvalid_r <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                ovf_r <= 1'b0;
            end
            if (word_done_s) begin
                if (!dvalid_r || DREADY) begin
                    dout_r   <= word_s;
                    dvalid_r <= 1'b1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end else if (DREADY) begin
                dvalid_r <= 1'b0;
            end
        end
    end

    assign DDR_CE  = ddr_ce_r;
    assign DDR_CLR = ddr_clr_r;
    assign DOUT    = dout_r;
    assign DVALID  = dvalid_r;
    assign LOCKED  = locked_r;
    assign OVF     = ovf_r;

endmodule

// File: tb/tb_iddr_capture_ctrl.sv
// Scoreboard bench for iddr_capture_ctrl: directed pair streams, accepted words checked by a monitor.
// With IDDR_CAPTURE_BITSLIP_EN defined, an odd-alignment lock case is also run.
module tb_iddr_capture_ctrl;

    logic       C = 1'b0;
    logic       R_N = 1'b0;
    logic       EN = 1'b0;
    logic       Q0 = 1'b0;
    logic       Q1 = 1'b0;
    logic       DREADY = 1'b0;
    logic       DDR_CE;
    logic       DDR_CLR;
    logic [7:0] DOUT;
    logic       DVALID;
    logic       LOCKED;
    logic       OVF;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    iddr_capture_ctrl dut (
        .C       (C),
        .R_N     (R_N),
        .EN      (EN),
        .Q0      (Q0),
        .Q1      (Q1),
        .DDR_CE  (DDR_CE),
        .DDR_CLR (DDR_CLR),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .DREADY  (DREADY),
        .LOCKED  (LOCKED),
        .OVF     (OVF)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic cyc(input logic en, input logic [1:0] p, input logic rdy);
        EN     = en;
        Q0     = p[1];
        Q1     = p[0];
        DREADY = rdy;
        @(posedge C);
        #1;
    endtask

    // Send one byte MSB-first as four Q0/Q1 pairs; rdy bit 3 goes with the first pair.
    task automatic send_word(input logic [7:0] b, input logic [3:0] rdy, input bit push);
        for (int i = 0; i < 4; i++) begin
            if (push && (i == 3)) exp_q.push_back(b);
            cyc(1'b1, b[7-2*i -: 2], rdy[3-i]);
        end
    endtask

    // IDLE -> FLUSH (two cycles) -> HUNT, checking the DDR clear/enable sequence.
    task automatic start_capture();
        cyc(1'b1, 2'b00, 1'b1);
        chk("flush1_clr", DDR_CLR, 1);
        chk("flush1_ovf", OVF, 0);
        cyc(1'b1, 2'b00, 1'b1);
        chk("flush2_clr", DDR_CLR, 1);
        chk("flush2_ce", DDR_CE, 0);
        cyc(1'b1, 2'b00, 1'b1);
        chk("hunt_clr", DDR_CLR, 0);
        chk("hunt_ce", DDR_CE, 1);
    endtask

    task automatic lock_a5();
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        chk("prelock", LOCKED, 0);
        cyc(1'b1, 2'b01, 1'b1);
        chk("lock_a5", LOCKED, 1);
        chk("sync_not_output", DVALID, 0);
    endtask

    // Monitor: any word accepted on the coming edge must be the oldest expected one.
    always @(negedge C) begin
        if (R_N && DVALID && DREADY) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", DOUT);
            end else begin
                chk("scoreboard_word", DOUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset held three cycles, then released with EN=0.
        R_N = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0);
        R_N = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        chk("rst_dout", DOUT, 0);
        chk("rst_dvalid", DVALID, 0);
        chk("rst_locked", LOCKED, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_ce", DDR_CE, 0);
        chk("rst_clr", DDR_CLR, 0);

        // Lock on A5 and capture CC.
        start_capture();
        lock_a5();
        send_word(8'hCC, 4'b1111, 1'b1);
        chk("cc_dout", DOUT, 8'hCC);
        chk("cc_dvalid", DVALID, 1);

        // Next word 81: CC is taken on the first pair so DVALID drops for one pulse.
        cyc(1'b1, 2'b10, 1'b1);
        chk("cc_pulse_end", DVALID, 0);
        cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b1, 2'b00, 1'b1);
        exp_q.push_back(8'h81);
        cyc(1'b1, 2'b01, 1'b1);
        chk("w81_dout", DOUT, 8'h81);

        // Accept 81 on the same edge that 69 completes.
        send_word(8'h69, 4'b0001, 1'b1);
        chk("simul_dout", DOUT, 8'h69);
        chk("simul_dvalid", DVALID, 1);
        chk("simul_ovf", OVF, 0);

        // Backpressure: 12 held, 34 dropped.
        send_word(8'h12, 4'b1000, 1'b1);
        chk("w12_dout", DOUT, 8'h12);
        send_word(8'h34, 4'b0000, 1'b0);
        chk("bp_hold", DOUT, 8'h12);
        chk("bp_ovf", OVF, 1);
        chk("bp_dvalid", DVALID, 1);
        cyc(1'b1, 2'b01, 1'b1);
        chk("bp_release", DVALID, 0);
        chk("bp_ovf_sticky", OVF, 1);
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b1, 2'b01, 1'b0);
        cyc(1'b1, 2'b10, 1'b0);
        chk("w56_dout", DOUT, 8'h56);

        // Abort at phase 2 with 56 still pending.
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b0, 2'b00, 1'b0);
        chk("abort_dvalid", DVALID, 0);
        chk("abort_locked", LOCKED, 0);
        chk("abort_ce", DDR_CE, 0);
        chk("abort_ovf_kept", OVF, 1);
        start_capture();

        // Relock, then reset mid-word with EN still high.
        lock_a5();
        cyc(1'b1, 2'b11, 1'b0);
        cyc(1'b1, 2'b11, 1'b0);
        R_N = 1'b0;
        cyc(1'b1, 2'b11, 1'b1);
        chk("midrst_locked", LOCKED, 0);
        chk("midrst_ce", DDR_CE, 0);
        chk("midrst_dout", DOUT, 0);
        chk("midrst_dvalid", DVALID, 0);
        R_N = 1'b1;
        cyc(1'b0, 2'b00, 1'b0);
        chk("midrst_idle_clr", DDR_CLR, 0);

`ifdef IDDR_CAPTURE_BITSLIP_EN
        // Zero bit, A5, 3C, pad: A5 sits on the odd alignment.
        start_capture();
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b1, 2'b10, 1'b1);
        cyc(1'b1, 2'b10, 1'b1);
        chk("slip_lock", LOCKED, 1);
        cyc(1'b1, 2'b01, 1'b1);
        cyc(1'b1, 2'b11, 1'b1);
        cyc(1'b1, 2'b10, 1'b1);
        exp_q.push_back(8'h3C);
        cyc(1'b1, 2'b00, 1'b1);
        chk("slip_dout", DOUT, 8'h3C);
        chk("slip_dvalid", DVALID, 1);
`endif

        cyc(1'b1, 2'b00, 1'b1);
        cyc(1'b0, 2'b00, 1'b1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
